csync_separator: RTL

- Parametrised composite-sync separator for the ZX80/ZX81 display path.
- Takes the raw core `csync` and produces clean, filtered hsync/vsync levels, one-cycle line/frame strobes, a line counter and a measured lines-per-frame value.
- Sits between `fpga_zx81` and the LCD/DVI sync consumers, running on the system clock domain.
- Generalises the fixed 11-bit low-time counter with selectable polarity, glitch filtering, a programmable vsync threshold and frame measurement.

---
 rtl/csync_separator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/csync_separator.sv
`default_nettype none
// ============================================================================
//  Module      : csync_separator
//  Description : Composite-sync separator for the ZX80/ZX81 display path.
//                Synchronises and glitch-filters the raw csync input, then
//                derives hsync/vsync levels, line/frame strobes, a line
//                counter and the measured lines-per-frame value.
//                Optional frame-lock detector: define CSYNC_SEPARATOR_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module csync_separator #(
    parameter int CNT_W            = 11,
    parameter int VS_THRESH        = 1024,
    parameter int FILT_LEN         = 3,
    parameter int CSYNC_ACTIVE_LOW = 1,
    parameter int LINE_W           = 10,
    parameter int LOCK_FRAMES      = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              csync,
    output logic              hsync,
    output logic              vsync,
    output logic              hs_stb,
    output logic              vs_stb,
    output logic [LINE_W-1:0] line,
    output logic [LINE_W-1:0] lines_per_frame,
    output logic              locked
);

    // Raw csync level that means "no sync pulse"
    localparam logic              SYNC_IDLE = (CSYNC_ACTIVE_LOW != 0);
    localparam logic [3:0]        FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [3:0]        FCNT_ONE  = 4'd1;
    localparam logic [CNT_W-1:0]  VS_CMP    = CNT_W'(VS_THRESH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LINE_W-1:0] LINE_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);

    logic [1:0]        sync_q;
    logic              act;
    logic              filt_q, filt_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              hsync_q, hs_stb_q, hs_stb_d;
    logic              vsync_q, vsync_d, vs_stb_q, vs_stb_d, vs_set;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d, lpf_q, lpf_d;

    // Two-flop synchroniser for the asynchronous csync input
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) sync_q <= {SYNC_IDLE, SYNC_IDLE};
        else          sync_q <= {sync_q[0], csync};
    end

    // act = 1 means a sync pulse, regardless of input polarity
    assign act = sync_q[1] ^ SYNC_IDLE;

    // Agreement filter: f follows act only after FILT_LEN disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (act == filt_q) begin
            fcnt_d = 4'd0;
        end else if (fcnt_q == FILT_LAST) begin
            filt_d = act;
            fcnt_d = 4'd0;
        end else begin
            fcnt_d = fcnt_q + FCNT_ONE;
        end
    end

    // Pulse timing: counter runs while hsync is up, so vsync lands VS_THRESH
    // clocks after the hsync rise and drops on the same edge as hsync
    always_comb begin
        hs_stb_d = filt_q & ~hsync_q;
        cnt_d    = '0;
        if (filt_q && hsync_q)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        vs_set   = filt_q & hsync_q & (cnt_q == VS_CMP);
        vsync_d  = filt_q & (vsync_q | vs_set);
        vs_stb_d = vs_set & ~vsync_q;
    end

    // Line counting; updates land in the same cycle as the strobe outputs
    always_comb begin
        line_d = line_q;
        lpf_d  = lpf_q;
        if (vs_stb_d) begin
            lpf_d  = line_q;
            line_d = '0;
        end else if (hs_stb_d && line_q != LINE_MAX) begin
            line_d = line_q + LINE_ONE;
        end
    end

    // Main state registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_q   <= 1'b0;
            fcnt_q   <= 4'd0;
            hsync_q  <= 1'b0;
            hs_stb_q <= 1'b0;
            cnt_q    <= '0;
            vsync_q  <= 1'b0;
            vs_stb_q <= 1'b0;
            line_q   <= '0;
            lpf_q    <= '0;
        end else begin
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            hsync_q  <= filt_q;
            hs_stb_q <= hs_stb_d;
            cnt_q    <= cnt_d;
            vsync_q  <= vsync_d;
            vs_stb_q <= vs_stb_d;
            line_q   <= line_d;
            lpf_q    <= lpf_d;
        end
    end

`ifdef CSYNC_SEPARATOR_LOCK_EN
    localparam int              LOCK_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_FRAMES);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q;

    // Count consecutive frames whose length matches the previous one;
    // a runaway line count (no vsync) also breaks lock
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (vs_stb_d) begin
            if (line_q == lpf_q && line_q != '0)
                lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? LOCK_TGT : lock_cnt_q + LOCK_ONE;
            else
                lock_cnt_d = '0;
        end else if (hs_stb_d && line_q == LINE_MAX) begin
            lock_cnt_d = '0;
        end
    end

    // Lock state registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (lock_cnt_d == LOCK_TGT);
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign hs_stb          = hs_stb_q;
    assign vs_stb          = vs_stb_q;
    assign line            = line_q;
    assign lines_per_frame = lpf_q;

endmodule
`default_nettype wire
